regfile_wb_writer: RTL and testbench

Write-side driver of the register file. It accepts results from the ALU and load channels through valid/ready handshakes, formats load data, and arbitrates between the two sources. It drives the register file write port (wen/rd/dIn) from a registered output stage. It also keeps a pending-write scoreboard and forwards data combinationally to both read ports. It sits between execute/memory and regFile.

---
 rtl/core_pkg.sv | 14 +
 rtl/regfile_wb_writer_if.sv | 50 +++++
 rtl/load_formatter.sv | 38 +++
 rtl/regfile_wb_writer.sv | 86 ++++++++
 tb/tb_regfile_wb_writer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core constants: datapath widths and RV32I load funct3 encodings.
package core_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/regfile_wb_writer_if.sv
// Writeback bus between execute/memory, this writer and the register file.
interface regfile_wb_writer_if;
  import core_pkg::*;

  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            ld_valid;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            ld_ready;

  logic            wen;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] dIn;

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic [XLEN-1:0] r1_fwd;
  logic [XLEN-1:0] r2_fwd;
  logic            rs1_busy;
  logic            rs2_busy;

  modport master (
    output iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
           ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
           rs1, rs2, r1, r2,
    input  iss_ready, alu_ready, ld_ready, wen, rd, dIn,
           r1_fwd, r2_fwd, rs1_busy, rs2_busy
  );

  modport slave (
    input  iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
           ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
           rs1, rs2, r1, r2,
    output iss_ready, alu_ready, ld_ready, wen, rd, dIn,
           r1_fwd, r2_fwd, rs1_busy, rs2_busy
  );

endinterface

// File: rtl/load_formatter.sv
// Extracts the addressed byte/halfword of a load word and sign/zero extends it.
// Purely combinational; unknown funct3 encodings fall back to a full word.
module load_formatter
  import core_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    // Misaligned halfwords are not trapped here; bit 0 of the offset is ignored.
    half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/regfile_wb_writer.sv
// Register-file write driver: load/ALU arbitration into a registered write port,
// a pending-write scoreboard for WAW stalls, and combinational read forwarding.
module regfile_wb_writer
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  regfile_wb_writer_if.slave bus
);

  logic [XLEN-1:0] ld_fmt;

  load_formatter u_load_formatter (
    .funct3_i  (bus.ld_funct3),
    .addr_lo_i (bus.ld_addr_lo),
    .data_i    (bus.ld_data),
    .data_o    (ld_fmt)
  );

  logic            wen_q, wen_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] din_q, din_d;
  logic [NREG-1:0] pend_q, pend_d;

  logic            acc;
  logic [AW-1:0]   acc_rd;
  logic [XLEN-1:0] acc_dat;
  logic            iss_fire;

  // Loads win outright; the ALU simply waits while a load is presented.
  assign bus.ld_ready  = 1'b1;
  assign bus.alu_ready = !bus.ld_valid;

  always_comb begin
    acc     = bus.ld_valid || bus.alu_valid;
    acc_rd  = bus.ld_valid ? bus.ld_rd : bus.alu_rd;
    acc_dat = bus.ld_valid ? ld_fmt    : bus.alu_data;
  end

  // x0 results are consumed but never reach the port, so rd/dIn keep their last write.
  always_comb begin
    wen_d = acc && (acc_rd != '0);
    rd_d  = wen_d ? acc_rd  : rd_q;
    din_d = wen_d ? acc_dat : din_q;
  end

  assign bus.iss_ready = !pend_q[bus.iss_rd] || (wen_q && (rd_q == bus.iss_rd));
  assign iss_fire      = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);

  // Clear first so a same-edge re-issue of the retiring register keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (wen_q) begin
      pend_d[rd_q] = 1'b0;
    end
    if (iss_fire) begin
      pend_d[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      rd_q   <= '0;
      din_q  <= '0;
      pend_q <= '0;
    end else begin
      wen_q  <= wen_d;
      rd_q   <= rd_d;
      din_q  <= din_d;
      pend_q <= pend_d;
    end
  end

  assign bus.wen = wen_q;
  assign bus.rd  = rd_q;
  assign bus.dIn = din_q;

  // pend[0] is never set, so x0 reads are never busy or forwarded.
  assign bus.rs1_busy = pend_q[bus.rs1] && !(wen_q && (rd_q == bus.rs1));
  assign bus.rs2_busy = pend_q[bus.rs2] && !(wen_q && (rd_q == bus.rs2));

  assign bus.r1_fwd = (wen_q && (rd_q == bus.rs1) && (bus.rs1 != '0)) ? din_q : bus.r1;
  assign bus.r2_fwd = (wen_q && (rd_q == bus.rs2) && (bus.rs2 != '0)) ? din_q : bus.r2;

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed bench for regfile_wb_writer: load-format table plus hand sequences.
module tb_regfile_wb_writer;
  import core_pkg::*;

  logic clk;
  logic rst_n;

  regfile_wb_writer_if bus ();

  regfile_wb_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  typedef struct {
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] data;
    logic [4:0]  dst;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iss_valid  = 1'b0;
    bus.iss_rd     = '0;
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_data   = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = '0;
    bus.ld_data    = '0;
    bus.ld_funct3  = '0;
    bus.ld_addr_lo = '0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.r1         = '0;
    bus.r2         = '0;
  endtask

  task automatic chk_no_pending(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < NREG; i++) begin
      bus.rs1 = i[4:0];
      #1;
      if (bus.rs1_busy !== 1'b0) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle_inputs();

    vecs[0]  = '{F3_LB,  2'd3, 32'h80F17F02, 5'd1,  32'hFFFFFF80};
    vecs[1]  = '{F3_LBU, 2'd3, 32'h80F17F02, 5'd2,  32'h00000080};
    vecs[2]  = '{F3_LH,  2'd2, 32'h80F17F02, 5'd3,  32'hFFFF80F1};
    vecs[3]  = '{F3_LHU, 2'd0, 32'h80F17F02, 5'd4,  32'h00007F02};
    vecs[4]  = '{3'b011, 2'd0, 32'h80F17F02, 5'd6,  32'h80F17F02};
    vecs[5]  = '{F3_LW,  2'd0, 32'h80F17F02, 5'd9,  32'h80F17F02};
    vecs[6]  = '{F3_LB,  2'd2, 32'h80F17F02, 5'd11, 32'hFFFFFFF1};
    vecs[7]  = '{F3_LB,  2'd1, 32'h80F17F02, 5'd13, 32'h0000007F};
    vecs[8]  = '{F3_LBU, 2'd0, 32'h80F17F02, 5'd14, 32'h00000002};
    vecs[9]  = '{F3_LHU, 2'd2, 32'h80F17F02, 5'd15, 32'h000080F1};
    vecs[10] = '{F3_LH,  2'd0, 32'h80F17F02, 5'd16, 32'h00007F02};
    vecs[11] = '{3'b111, 2'd1, 32'h80F17F02, 5'd31, 32'h80F17F02};

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("reset_wen", {31'b0, bus.wen}, 32'd0);
    chk("reset_rd",  {27'b0, bus.rd},  32'd0);
    chk("reset_din", bus.dIn,          32'd0);
    rst_n = 1'b1;
    step();

    // ALU write and forwarding
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hBABEFACE;
    bus.rs1 = 5'd2;  bus.r1 = 32'h22222222;
    bus.rs2 = 5'd10; bus.r2 = 32'h11111111;
    step();
    bus.alu_valid = 1'b0;
    #1;
    chk("alu_wen",    {31'b0, bus.wen}, 32'd1);
    chk("alu_rd",     {27'b0, bus.rd},  32'd10);
    chk("alu_din",    bus.dIn,          32'hBABEFACE);
    chk("alu_r2_fwd", bus.r2_fwd,       32'hBABEFACE);
    chk("alu_r1_raw", bus.r1_fwd,       32'h22222222);
    step();
    chk("alu_idle_wen",  {31'b0, bus.wen}, 32'd0);
    chk("alu_idle_rd",   {27'b0, bus.rd},  32'd10);
    chk("alu_idle_fwd",  bus.r2_fwd,       32'h11111111);

    // Simultaneous load and ALU
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h80F17F02;
    bus.ld_funct3 = F3_LW; bus.ld_addr_lo = 2'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h00000055;
    #1;
    chk("both_ld_ready",  {31'b0, bus.ld_ready},  32'd1);
    chk("both_alu_ready", {31'b0, bus.alu_ready}, 32'd0);
    step();
    bus.ld_valid = 1'b0;
    #1;
    chk("both_first_rd",  {27'b0, bus.rd},          32'd7);
    chk("both_first_din", bus.dIn,                  32'h80F17F02);
    chk("alu_ready_free", {31'b0, bus.alu_ready},   32'd1);
    step();
    bus.alu_valid = 1'b0;
    chk("both_second_wen", {31'b0, bus.wen}, 32'd1);
    chk("both_second_rd",  {27'b0, bus.rd},  32'd8);
    chk("both_second_din", bus.dIn,          32'h00000055);
    step();
    chk("both_done_wen", {31'b0, bus.wen}, 32'd0);

    // Load formatting table
    for (int i = 0; i < 12; i++) begin
      bus.ld_valid   = 1'b1;
      bus.ld_rd      = vecs[i].dst;
      bus.ld_data    = vecs[i].data;
      bus.ld_funct3  = vecs[i].funct3;
      bus.ld_addr_lo = vecs[i].off;
      step();
      bus.ld_valid = 1'b0;
      chk($sformatf("ld_vec%0d_din", i), bus.dIn, vecs[i].exp);
      chk($sformatf("ld_vec%0d_rd", i), {27'b0, bus.rd}, {27'b0, vecs[i].dst});
    end
    step();

    // x0 result is consumed without a write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h00001234;
    bus.rs1 = 5'd0; bus.r1 = 32'hCAFE0001;
    #1;
    chk("x0_alu_ready", {31'b0, bus.alu_ready}, 32'd1);
    step();
    bus.alu_valid = 1'b0;
    chk("x0_wen",      {31'b0, bus.wen},      32'd0);
    chk("x0_r1_raw",   bus.r1_fwd,            32'hCAFE0001);
    chk("x0_rs1_busy", {31'b0, bus.rs1_busy}, 32'd0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1;
    chk("x0_iss_ready", {31'b0, bus.iss_ready}, 32'd1);
    step();
    bus.iss_valid = 1'b0;
    chk_no_pending("x0_no_pend");

    // Scoreboard WAW
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    bus.rs1 = 5'd5; bus.r1 = 32'h0;
    #1;
    chk("waw_first_ready", {31'b0, bus.iss_ready}, 32'd1);
    step();
    chk("waw_rs1_busy",     {31'b0, bus.rs1_busy},  32'd1);
    chk("waw_second_stall", {31'b0, bus.iss_ready}, 32'd0);
    step();
    chk("waw_still_stall",  {31'b0, bus.iss_ready}, 32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h00000077;
    step();
    bus.alu_valid = 1'b0;
    #1;
    chk("waw_wr_iss_ready", {31'b0, bus.iss_ready}, 32'd1);
    chk("waw_wr_busy",      {31'b0, bus.rs1_busy},  32'd0);
    chk("waw_wr_fwd",       bus.r1_fwd,             32'h00000077);
    step();
    bus.iss_valid = 1'b0;
    chk("waw_reissue_pend", {31'b0, bus.rs1_busy}, 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h00000078;
    step();
    bus.alu_valid = 1'b0;
    step();
    chk("waw_cleared", {31'b0, bus.rs1_busy}, 32'd0);

    // Reset in the middle of a write with a pending register
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
    step();
    bus.iss_valid = 1'b0;
    bus.rs2 = 5'd12;
    #1;
    chk("mid_pre_busy", {31'b0, bus.rs2_busy}, 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hDEADBEEF;
    step();
    bus.alu_valid = 1'b0;
    chk("mid_wen_before", {31'b0, bus.wen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", {31'b0, bus.wen}, 32'd0);
    chk("mid_rst_din", bus.dIn,          32'd0);
    chk("mid_rst_rd",  {27'b0, bus.rd},  32'd0);
    chk_no_pending("mid_rst_pend");
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_wen", {31'b0, bus.wen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
